rca_4bit: RTL and testbench
===========================

Name: rca_4bit

Overview:
Registered N-bit ripple-carry adder, default 4 bits: sum = x + y + c_in with carry-out. The datapath is a chain of 1-bit full-adder cells, with carry rippling from LSB to MSB. Results are captured in an output register with a valid flag. Used as a small arithmetic leaf in datapaths that need a pipelined, deterministic-latency add.

Parameters:
- WIDTH, 4, operand/sum width in bits; legal range 1..32.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset; sampled on rising clk.
- in_valid  input  1  qualifies x/y/c_in this cycle.
- x  input  WIDTH  addend A, unsigned.
- y  input  WIDTH  addend B, unsigned.
- c_in  input  1  carry-in to bit 0.
- out_valid  output  1  sum/c_out hold a result computed from a valid input.
- sum  output  WIDTH  registered (x + y + c_in) mod 2^WIDTH.
- c_out  output  1  registered carry out of bit WIDTH-1.

Behaviour:
- Reset is synchronous and active-high on clk: while rst=1 at a rising edge, sum=0, c_out=0, out_valid=0 (and overflow=0 when enabled). Reset overrides in_valid in the same cycle.
- Combinational core: WIDTH full-adder cells.
  - s[i] = x[i]^y[i]^c[i].
  - c[i+1] = x[i]&y[i] | c[i]&(x[i]^y[i]).
  - c[0] = c_in; carry out = c[WIDTH].
  - No carry-lookahead; ripple structure is required.
- Latency is exactly 1 cycle. An edge with in_valid=1 and rst=0 loads sum and c_out from the current x/y/c_in and sets out_valid=1 on the next cycle.
- An edge with in_valid=0 and rst=0 clears out_valid to 0. sum and c_out hold their last values; they are not cleared.
- Throughput is one add per cycle. Back-to-back valids are allowed. There is no backpressure: there is no ready signal and the consumer must accept every out_valid pulse.
- Arithmetic is unsigned. {c_out, sum} = x + y + c_in exactly, as a WIDTH+1-bit result. Max case: all-ones + all-ones + 1 = 2^(WIDTH+1)-1.
- Wrap-around: the sum bits are modulo 2^WIDTH; c_out=1 whenever the true result is ≥ 2^WIDTH.
- Reset asserted mid-stream: the result of an in-flight cycle is discarded (out_valid=0 after the reset edge). Normal operation resumes on the first edge with rst=0.
- X/Y/c_in are don't-care when in_valid=0, and must not affect outputs.

Optional Feature:
- Macro RCA_OVERFLOW_EN.
- When defined, it adds output port overflow (output, 1 bit): registered two's-complement signed overflow, c[WIDTH]^c[WIDTH-1].
  - overflow updates under the same in_valid/reset rules as c_out.
  - Its reset value is 0.
- When undefined, the port and logic are absent and the interface is exactly as listed above.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, x=4'hF, y=4'hF -> sum=0, c_out=0, out_valid=0 throughout. After rst is released, the first valid input appears 1 cycle later.
- Directed sweep with c_in=0, in_valid=1, applied back-to-back. Each result is valid one cycle after its input:
  - 0+0 -> sum=0, c_out=0.
  - 1+1 -> sum=2, c_out=0.
  - 2+1 -> sum=3, c_out=0.
  - 3+3 -> sum=6, c_out=0.
  - 4+3 -> sum=7, c_out=0.
  - 7+6 -> sum=D, c_out=0.
  - 8+7 -> sum=F, c_out=0.
  - F+F -> sum=E, c_out=1.
- Carry ripple through all cells: x=F, y=0, c_in=1 -> sum=0, c_out=1. x=F, y=F, c_in=1 -> sum=F, c_out=1.
- Valid gating: a valid add of 3+3 followed by in_valid=0 with x=9, y=9 -> out_valid goes 1 then 0, and sum stays 6.
- Reset mid-stream: a valid add of 7+6 with rst=1 at that same edge -> out_valid=0 and sum=0 the next cycle.
- With RCA_OVERFLOW_EN: 7+1 -> overflow=1, sum=8. 8+8 -> overflow=1, sum=0, c_out=1. 3+2 -> overflow=0.

Source files
------------

// File: rtl/rca_4bit.sv
// Registered WIDTH-bit ripple-carry adder: {c_out, sum} = x + y + c_in, one-cycle latency.
// Define RCA_OVERFLOW_EN to add a registered two's-complement overflow output.
module rca_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef RCA_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  // One full-adder cell; returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
    full_add = {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
  endfunction

  logic [WIDTH:0]   carry_s;
  logic [WIDTH-1:0] sum_s;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
`ifdef RCA_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  // Carry ripples cell by cell from bit 0 to bit WIDTH-1.
  always_comb begin
    carry_s    = {(WIDTH+1){1'b0}};
    sum_s      = {WIDTH{1'b0}};
    carry_s[0] = c_in;
    for (int i = 0; i < WIDTH; i++) begin
      {carry_s[i+1], sum_s[i]} = full_add(x[i], y[i], carry_s[i]);
    end
  end

  // Next-state: load on valid input, otherwise hold the result and drop valid.
  always_comb begin
    valid_d = 1'b0;
    sum_d   = sum_q;
    c_out_d = c_out_q;
`ifdef RCA_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    if (in_valid) begin
      valid_d = 1'b1;
      sum_d   = sum_s;
      c_out_d = carry_s[WIDTH];
`ifdef RCA_OVERFLOW_EN
      ovf_d   = carry_s[WIDTH] ^ carry_s[WIDTH-1];
`endif
    end else begin
      valid_d = 1'b0;
    end
  end

  // Output register with synchronous reset taking priority over in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      sum_q   <= {WIDTH{1'b0}};
      c_out_q <= 1'b0;
`ifdef RCA_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
`ifdef RCA_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign out_valid = valid_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
`ifdef RCA_OVERFLOW_EN
  assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_rca_4bit.sv
// Self-checking bench for rca_4bit: directed spec cases plus a randomized stream
// checked against an arithmetic reference model.
module tb_rca_4bit;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         c_in = 1'b0;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         c_out;
`ifdef RCA_OVERFLOW_EN
  logic         overflow;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rca_4bit #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .x(x),
    .y(y),
    .c_in(c_in),
    .out_valid(out_valid),
    .sum(sum),
    .c_out(c_out)
`ifdef RCA_OVERFLOW_EN
    ,
    .overflow(overflow)
`endif
  );

  // Unsigned reference: the exact (W+1)-bit result of a + b + ci.
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    int t;
    t = int'(a) + int'(b) + int'(ci);
    return t[W:0];
  endfunction

  // Signed reference: overflow when the signed sum leaves the W-bit range.
  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    int sa, sb, s;
    sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
    sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
    s  = sa + sb + int'(ci);
    return (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
  endfunction

  task automatic apply(input logic r, input logic v, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic ci);
    @(negedge clk);
    rst = r; in_valid = v; x = a; y = b; c_in = ci;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      apply(1'b1, 1'b1, 4'hF, 4'hF, 1'b1);
      vectors++;
      if ({out_valid, c_out, sum} !== {1'b0, 1'b0, 4'h0}) begin
        miscompares++;
        $display("FAIL reset[%0d]: got v=%b c=%b s=%h, want v=0 c=0 s=0", k, out_valid, c_out, sum);
      end
    end
    apply(1'b0, 1'b1, 4'h2, 4'h3, 1'b0);
    vectors++;
    if ({out_valid, c_out, sum} !== {1'b1, 1'b0, 4'h5}) begin
      miscompares++;
      $display("FAIL reset_release: got v=%b c=%b s=%h, want v=1 c=0 s=5", out_valid, c_out, sum);
    end
  endtask

  task automatic test_directed_sweep();
    logic [W-1:0] ax [8] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h7, 4'h8, 4'hF};
    logic [W-1:0] ay [8] = '{4'h0, 4'h1, 4'h1, 4'h3, 4'h3, 4'h6, 4'h7, 4'hF};
    logic [W-1:0] es [8] = '{4'h0, 4'h2, 4'h3, 4'h6, 4'h7, 4'hD, 4'hF, 4'hE};
    logic         ec [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 8; k++) begin
      apply(1'b0, 1'b1, ax[k], ay[k], 1'b0);
      vectors++;
      if ({out_valid, c_out, sum} !== {1'b1, ec[k], es[k]}) begin
        miscompares++;
        $display("FAIL sweep %h+%h: got v=%b c=%b s=%h, want v=1 c=%b s=%h",
                 ax[k], ay[k], out_valid, c_out, sum, ec[k], es[k]);
      end
    end
  endtask

  task automatic test_carry_ripple();
    apply(1'b0, 1'b1, 4'hF, 4'h0, 1'b1);
    vectors++;
    if ({out_valid, c_out, sum} !== {1'b1, 1'b1, 4'h0}) begin
      miscompares++;
      $display("FAIL ripple F+0+1: got c=%b s=%h, want c=1 s=0", c_out, sum);
    end
    apply(1'b0, 1'b1, 4'hF, 4'hF, 1'b1);
    vectors++;
    if ({out_valid, c_out, sum} !== {1'b1, 1'b1, 4'hF}) begin
      miscompares++;
      $display("FAIL ripple F+F+1: got c=%b s=%h, want c=1 s=F", c_out, sum);
    end
  endtask

  task automatic test_valid_gating();
    apply(1'b0, 1'b1, 4'h3, 4'h3, 1'b0);
    vectors++;
    if ({out_valid, c_out, sum} !== {1'b1, 1'b0, 4'h6}) begin
      miscompares++;
      $display("FAIL gating_valid: got v=%b c=%b s=%h, want v=1 c=0 s=6", out_valid, c_out, sum);
    end
    apply(1'b0, 1'b0, 4'h9, 4'h9, 1'b1);
    vectors++;
    if ({out_valid, c_out, sum} !== {1'b0, 1'b0, 4'h6}) begin
      miscompares++;
      $display("FAIL gating_hold: got v=%b c=%b s=%h, want v=0 c=0 s=6", out_valid, c_out, sum);
    end
  endtask

  task automatic test_reset_midstream();
    apply(1'b0, 1'b1, 4'h1, 4'h1, 1'b0);
    apply(1'b1, 1'b1, 4'h7, 4'h6, 1'b0);
    vectors++;
    if ({out_valid, c_out, sum} !== {1'b0, 1'b0, 4'h0}) begin
      miscompares++;
      $display("FAIL mid_reset: got v=%b c=%b s=%h, want v=0 c=0 s=0", out_valid, c_out, sum);
    end
    apply(1'b0, 1'b1, 4'h7, 4'h6, 1'b0);
    vectors++;
    if ({out_valid, c_out, sum} !== {1'b1, 1'b0, 4'hD}) begin
      miscompares++;
      $display("FAIL mid_resume: got v=%b c=%b s=%h, want v=1 c=0 s=D", out_valid, c_out, sum);
    end
  endtask

`ifdef RCA_OVERFLOW_EN
  task automatic test_overflow();
    apply(1'b0, 1'b1, 4'h7, 4'h1, 1'b0);
    vectors++;
    if ({overflow, sum} !== {1'b1, 4'h8}) begin
      miscompares++;
      $display("FAIL ovf 7+1: got o=%b s=%h, want o=1 s=8", overflow, sum);
    end
    apply(1'b0, 1'b1, 4'h8, 4'h8, 1'b0);
    vectors++;
    if ({overflow, c_out, sum} !== {1'b1, 1'b1, 4'h0}) begin
      miscompares++;
      $display("FAIL ovf 8+8: got o=%b c=%b s=%h, want o=1 c=1 s=0", overflow, c_out, sum);
    end
    apply(1'b0, 1'b1, 4'h3, 4'h2, 1'b0);
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf 3+2: got o=%b, want o=0", overflow);
    end
  endtask
`endif

  // Random back-to-back stream with gaps and occasional resets against a result-holding model.
  task automatic test_back_to_back_random();
    logic         ev = 1'b0;
    logic [W-1:0] es = '0;
    logic         ec = 1'b0;
    logic         eo = 1'b0;
    logic         r, v, ci;
    logic [W-1:0] a, b;
    logic [W:0]   full;
    apply(1'b1, 1'b0, '0, '0, 1'b0);
    for (int k = 0; k < 300; k++) begin
      r  = ($urandom_range(0, 15) == 0);
      v  = ($urandom_range(0, 3) != 0);
      a  = W'($urandom);
      b  = W'($urandom);
      ci = 1'($urandom);
      apply(r, v, a, b, ci);
      if (r) begin
        ev = 1'b0; es = '0; ec = 1'b0; eo = 1'b0;
      end else if (v) begin
        full = ref_add(a, b, ci);
        ev = 1'b1; es = full[W-1:0]; ec = full[W]; eo = ref_ovf(a, b, ci);
      end else begin
        ev = 1'b0;
      end
      vectors++;
      if ({out_valid, c_out, sum} !== {ev, ec, es}) begin
        miscompares++;
        $display("FAIL random[%0d] r=%b v=%b %h+%h+%b: got v=%b c=%b s=%h, want v=%b c=%b s=%h",
                 k, r, v, a, b, ci, out_valid, c_out, sum, ev, ec, es);
      end
`ifdef RCA_OVERFLOW_EN
      vectors++;
      if (overflow !== eo) begin
        miscompares++;
        $display("FAIL random_ovf[%0d] %h+%h+%b: got o=%b, want o=%b", k, a, b, ci, overflow, eo);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_directed_sweep();
    test_carry_ripple();
    test_valid_gating();
    test_reset_midstream();
`ifdef RCA_OVERFLOW_EN
    test_overflow();
`endif
    test_back_to_back_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
